// File: rtl/arbitro_pkg.sv
// Shared types and constants for the data-memory arbiter.
package arbitro_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam int WORD_BYTES = 4;
    localparam int DEPTH_DEF  = 256;

    // Requester index: 0 = CPU MEM stage, 1 = loader/debug port.
    typedef logic grant_t;

endpackage

// File: rtl/arbitro_selector.sv
// Combinational winner pick between the two requesters.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module arbitro_selector
    import arbitro_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_sel,
    output logic any_req
);

    assign any_req = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
    // On contention the requester that was not served last wins.
    always_comb begin
        grant_sel = 1'b0;
        if (req0 && req1)
            grant_sel = ~last_grant;
        else if (req1)
            grant_sel = 1'b1;
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    assign grant_sel = ~req0 & req1;
`endif

endmodule

// File: rtl/arbitro_mem_datos.sv
// Two-requester controller for the 256x8 big-endian data memory: one-cycle
// strobe per access, registered read data, out-of-range word accesses blocked.
module arbitro_mem_datos
    import arbitro_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] dir0,
    input  logic [31:0]   dato0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] dir1,
    input  logic [31:0]   dato1,
    output logic          ack0,
    output logic          ack1,
    output logic          err,
    output logic [31:0]   dato_s,
    output logic [AW-1:0] mem_dir,
    output logic [31:0]   mem_dato_e,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [31:0]   mem_dato_s
);

    localparam logic [AW-1:0] LIM = AW'(DEPTH - WORD_BYTES);

    state_t        state, state_nxt;
    grant_t        grant, last_grant, grant_sel;
    logic          any_req;
    logic          lat_we;
    logic [AW-1:0] lat_dir;
    logic [31:0]   lat_dato;
    logic          err_pending;
    logic          in_range;

    arbitro_selector u_sel (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .grant_sel  (grant_sel),
        .any_req    (any_req)
    );

    // Full-width unsigned compare so high address bits cannot alias into range.
    assign in_range = (lat_dir <= LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Memory-side outputs decode straight from state, so reset kills a strobe at once.
    always_comb begin
        state_nxt  = state;
        ack0       = 1'b0;
        ack1       = 1'b0;
        err        = 1'b0;
        mem_dir    = '0;
        mem_dato_e = '0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_dir    = lat_dir;
                mem_dato_e = lat_dato;
                if (in_range) begin
                    mem_write = lat_we;
                    mem_read  = ~lat_we;
                end
                state_nxt = DONE;
            end
            DONE: begin
                ack0      = ~grant;
                ack1      = grant;
                err       = err_pending;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_we      <= 1'b0;
            lat_dir     <= '0;
            lat_dato    <= '0;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            err_pending <= 1'b0;
            dato_s      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= grant_sel;
                        lat_we   <= grant_sel ? we1   : we0;
                        lat_dir  <= grant_sel ? dir1  : dir0;
                        lat_dato <= grant_sel ? dato1 : dato0;
                    end
                end
                ACCESS: begin
                    err_pending <= ~in_range;
                    if (in_range && !lat_we) dato_s <= mem_dato_s;
                end
                DONE: begin
                    last_grant <= grant;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_mem_datos.sv
// Directed, table-driven bench for arbitro_mem_datos with a behavioural 256x8
// big-endian memory attached to the memory port.
module tb_arbitro_mem_datos;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] dir0, dato0, dir1, dato1;
    logic        ack0, ack1, err;
    logic [31:0] dato_s, mem_dir, mem_dato_e, mem_dato_s;
    logic        mem_write, mem_read;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    arbitro_mem_datos #(.DEPTH(256), .AW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .we0        (we0),
        .dir0       (dir0),
        .dato0      (dato0),
        .req1       (req1),
        .we1        (we1),
        .dir1       (dir1),
        .dato1      (dato1),
        .ack0       (ack0),
        .ack1       (ack1),
        .err        (err),
        .dato_s     (dato_s),
        .mem_dir    (mem_dir),
        .mem_dato_e (mem_dato_e),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_dato_s (mem_dato_s)
    );

    // Data memory model: combinational big-endian read, write on the rising edge.
    logic [7:0] mem [256];
    logic [7:0] ma;
    assign ma = mem_dir[7:0];
    assign mem_dato_s = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};
    always @(posedge clk) begin
        if (mem_write) begin
            mem[ma]        <= mem_dato_e[31:24];
            mem[ma + 8'd1] <= mem_dato_e[23:16];
            mem[ma + 8'd2] <= mem_dato_e[15:8];
            mem[ma + 8'd3] <= mem_dato_e[7:0];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    endtask

    // One transaction on one port; call right after a rising edge with the FSM in IDLE.
    task automatic txn(input int port, input logic we, input logic [31:0] dir,
                       input logic [31:0] dato, output int ack_k, output int wr,
                       output int rd, output logic e, output logic [31:0] ds,
                       output logic [31:0] dseen, output logic [31:0] eseen,
                       output int wrong);
        ack_k = -1; wr = 0; rd = 0; e = 1'b0; ds = '0; dseen = '0; eseen = '0; wrong = 0;
        if (port == 0) begin req0 = 1'b1; we0 = we; dir0 = dir; dato0 = dato; end
        else           begin req1 = 1'b1; we1 = we; dir1 = dir; dato1 = dato; end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_write) wr++;
            if (mem_read)  rd++;
            if (mem_write || mem_read) begin dseen = mem_dir; eseen = mem_dato_e; end
            if ((port == 0) ? ack1 : ack0) wrong++;
            if ((port == 0) ? ack0 : ack1) begin
                ack_k = k; e = err; ds = dato_s;
                break;
            end
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] dir;
        logic [31:0] dato;
        int          wr;
        int          rd;
        logic        e;
        logic [31:0] ds;
    } vec_t;

    vec_t vt [13];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_k, wr, rd, wrong, n, acks;
        logic e;
        logic [31:0] ds, dseen, eseen;
        int g [4];
        int gexp [4];

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        vt[0]  = '{0, 1'b1, 32'h10,       32'hDEADBEEF, 1, 0, 1'b0, 32'h00000000};
        vt[1]  = '{0, 1'b0, 32'h10,       32'h0,        0, 1, 1'b0, 32'hDEADBEEF};
        vt[2]  = '{1, 1'b0, 32'hFD,       32'h0,        0, 0, 1'b1, 32'hDEADBEEF};
        vt[3]  = '{1, 1'b1, 32'hFC,       32'h11223344, 1, 0, 1'b0, 32'hDEADBEEF};
        vt[4]  = '{0, 1'b0, 32'hFC,       32'h0,        0, 1, 1'b0, 32'h11223344};
        vt[5]  = '{1, 1'b0, 32'h12,       32'h0,        0, 1, 1'b0, 32'hBEEF0000};
        vt[6]  = '{0, 1'b1, 32'h80000010, 32'hAAAAAAAA, 0, 0, 1'b1, 32'hBEEF0000};
        vt[7]  = '{0, 1'b0, 32'h10,       32'h0,        0, 1, 1'b0, 32'hDEADBEEF};
        vt[8]  = '{1, 1'b1, 32'hFD,       32'h99999999, 0, 0, 1'b1, 32'hDEADBEEF};
        vt[9]  = '{1, 1'b0, 32'hFC,       32'h0,        0, 1, 1'b0, 32'h11223344};
        vt[10] = '{0, 1'b1, 32'h04,       32'h01020304, 1, 0, 1'b0, 32'h11223344};
        vt[11] = '{1, 1'b1, 32'h08,       32'h05060708, 1, 0, 1'b0, 32'h11223344};
        vt[12] = '{0, 1'b1, 32'h20,       32'hCAFEF00D, 1, 0, 1'b0, 32'h11223344};

        req0 = 0; we0 = 0; dir0 = 0; dato0 = 0;
        req1 = 0; we1 = 0; dir1 = 0; dato1 = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ack0", 32'(ack0), 0);
        chk("rst_ack1", 32'(ack1), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_dato_s", dato_s, 0);
        chk("rst_mem_dir", mem_dir, 0);
        chk("rst_mem_dato_e", mem_dato_e, 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_mem_read", 32'(mem_read), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            txn(vt[i].port, vt[i].we, vt[i].dir, vt[i].dato, ack_k, wr, rd, e, ds, dseen, eseen, wrong);
            chk($sformatf("v%0d_ack_latency", i), 32'(ack_k), 2);
            chk($sformatf("v%0d_wr_pulses", i), 32'(wr), 32'(vt[i].wr));
            chk($sformatf("v%0d_rd_pulses", i), 32'(rd), 32'(vt[i].rd));
            chk($sformatf("v%0d_err", i), 32'(e), 32'(vt[i].e));
            chk($sformatf("v%0d_dato_s", i), ds, vt[i].ds);
            chk($sformatf("v%0d_other_ack", i), 32'(wrong), 0);
            if (vt[i].wr + vt[i].rd > 0) chk($sformatf("v%0d_mem_dir", i), dseen, vt[i].dir);
            if (vt[i].wr > 0) chk($sformatf("v%0d_mem_dato_e", i), eseen, vt[i].dato);
        end

        // Operand change during ACCESS must not reach the memory.
        req0 = 1'b1; we0 = 1'b0; dir0 = 32'h04;
        @(posedge clk); #1;
        dir0 = 32'h08;
        @(negedge clk);
        chk("opchg_mem_dir", mem_dir, 32'h04);
        chk("opchg_mem_read", 32'(mem_read), 1);
        @(negedge clk);
        chk("opchg_ack0", 32'(ack0), 1);
        chk("opchg_dato_s", dato_s, 32'h01020304);
        @(posedge clk); #1;
        req0 = 1'b0;

        // Reset asserted in the middle of an ACCESS write cycle.
        req0 = 1'b1; we0 = 1'b1; dir0 = 32'h20; dato0 = 32'h55AA55AA;
        @(posedge clk); #1;
        chk("rstacc_strobe_before", 32'(mem_write), 1);
        reset = 1'b1;
        #1;
        chk("rstacc_strobe_drop", 32'(mem_write), 0);
        req0 = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        chk("rstacc_no_ack", 32'(acks), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        txn(0, 1'b0, 32'h20, 32'h0, ack_k, wr, rd, e, ds, dseen, eseen, wrong);
        chk("rstacc_read_ack", 32'(ack_k), 2);
        chk("rstacc_read_data", ds, 32'hCAFEF00D);

        // Contention: both requesters held for four transactions from a fresh reset.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
`ifdef ARB_ROUND_ROBIN_EN
        gexp = '{0, 1, 0, 1};
`else
        gexp = '{0, 0, 0, 0};
`endif
        req0 = 1'b1; we0 = 1'b0; dir0 = 32'h10;
        req1 = 1'b1; we1 = 1'b0; dir1 = 32'hFC;
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            if (ack0)      begin g[n] = 0; n++; end
            else if (ack1) begin g[n] = 1; n++; end
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        chk("contend_ack_count", 32'(n), 4);
        for (int i = 0; i < 4; i++)
            if (i < n) chk($sformatf("contend_grant%0d", i), 32'(g[i]), 32'(gexp[i]));

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
